loadunit_mq: RTL and testbench

//  Parametrised multi-outstanding load unit; successor to the single-entry load FSM. Buffers up to

---
 rtl/loadunit_mq.sv | 192 +++++++++++++++++++
 tb/tb_loadunit_mq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loadunit_mq.sv
`default_nettype none
// ============================================================================
// Module   : loadunit_mq
// Purpose  : Multi-outstanding in-order load unit with a circular entry queue,
//            pipelined TBUS reads, load data extension and ROB-age flush.
// Revision : 1.0 - initial release
// ============================================================================
module loadunit_mq #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 64,
    parameter int PREG_W  = 6,
    parameter int ROB_LOG = 6
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               instr_valid_i,
    output logic               instr_ready_o,
    input  logic [PREG_W-1:0]  prd_i,
    input  logic [DATA_W-1:0]  src1_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic [3:0]         ls_size_i,
    input  logic               is_unsigned_i,
    input  logic               robidx_flag_i,
    input  logic [ROB_LOG-1:0] robidx_i,
    output logic               tbus_req_valid_o,
    input  logic               tbus_req_ready_i,
    output logic [DATA_W-1:0]  tbus_req_addr_o,
    output logic [1:0]         tbus_req_optype_o,
    input  logic               tbus_resp_valid_i,
    input  logic [DATA_W-1:0]  tbus_resp_data_i,
    input  logic               flush_valid_i,
    input  logic               flush_robidx_flag_i,
    input  logic [ROB_LOG-1:0] flush_robidx_i,
    output logic               wb_valid_o,
    output logic [PREG_W-1:0]  wb_prd_o,
    output logic               wb_robidx_flag_o,
    output logic [ROB_LOG-1:0] wb_robidx_o,
    output logic [DATA_W-1:0]  wb_data_o
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam int         PTR_W     = IDX_W + 1;
    localparam logic [1:0] TBUS_READ = 2'b00;

    logic [PTR_W-1:0]   head_q, issue_q, tail_q;
    logic [PTR_W-1:0]   head_d, issue_d, tail_d;
    logic [DEPTH-1:0]   valid_q, issued_q, killed_q;
    logic [DATA_W-1:0]  addr_q [DEPTH];
    logic [PREG_W-1:0]  prd_q  [DEPTH];
    logic               flag_q [DEPTH];
    logic [ROB_LOG-1:0] idx_q  [DEPTH];
    logic [3:0]         size_q [DEPTH];
    logic               uns_q  [DEPTH];

    logic               wb_valid_q, wb_flag_q;
    logic [PREG_W-1:0]  wb_prd_q;
    logic [ROB_LOG-1:0] wb_idx_q;
    logic [DATA_W-1:0]  wb_data_q;
    logic               post_reset_q;

    logic [PTR_W-1:0]   w_count, w_live_cnt, w_tail_fl;
    logic [IDX_W-1:0]   w_head_idx, w_issue_idx, w_tail_idx;
    logic [DEPTH-1:0]   w_valid_nx, w_issued_nx, w_killed_nx;
    logic               w_req_fire, w_resp_ok, w_alloc, w_wb_fire;
    logic [5:0]         w_shamt;
    logic [DATA_W-1:0]  w_shifted, w_ext;

    // Circular ROB age test; an entry at exactly the flush index survives.
    function automatic logic younger(input logic flag, input logic [ROB_LOG-1:0] idx,
                                     input logic fflag, input logic [ROB_LOG-1:0] fidx);
        return (flag ^ fflag) ^ (fidx < idx);
    endfunction

    assign w_count       = tail_q - head_q;
    assign instr_ready_o = (w_count != PTR_W'(DEPTH));
    assign w_head_idx    = head_q[IDX_W-1:0];
    assign w_issue_idx   = issue_q[IDX_W-1:0];
    assign w_tail_idx    = w_tail_fl[IDX_W-1:0];

    assign tbus_req_valid_o  = ~reset_i & valid_q[w_issue_idx] & ~issued_q[w_issue_idx]
                             & ~killed_q[w_issue_idx];
    assign tbus_req_addr_o   = addr_q[w_issue_idx];
    assign tbus_req_optype_o = TBUS_READ;

    assign w_req_fire = tbus_req_valid_o & tbus_req_ready_i;
    assign w_resp_ok  = tbus_resp_valid_i & valid_q[w_head_idx] & issued_q[w_head_idx];
    assign w_alloc    = instr_valid_i & instr_ready_o
                      & ~(flush_valid_i & younger(robidx_flag_i, robidx_i,
                                                  flush_robidx_flag_i, flush_robidx_i));
    assign w_wb_fire  = w_resp_ok & ~w_killed_nx[w_head_idx];

    always_comb begin
        w_issued_nx = issued_q;
        w_killed_nx = killed_q;
        w_valid_nx  = valid_q;
        w_live_cnt  = '0;
        if (w_req_fire) w_issued_nx[w_issue_idx] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_valid_i && valid_q[i] &&
                younger(flag_q[i], idx_q[i], flush_robidx_flag_i, flush_robidx_i))
                w_killed_nx[i] = 1'b1;
            // Killed loads never sent to TBUS have no response to wait for.
            if (valid_q[i] && !w_issued_nx[i] && w_killed_nx[i])
                w_valid_nx[i] = 1'b0;
            if (valid_q[i] && !w_issued_nx[i] && !w_killed_nx[i])
                w_live_cnt = w_live_cnt + PTR_W'(1);
        end
        if (w_resp_ok) w_valid_nx[w_head_idx] = 1'b0;
        issue_d   = issue_q + {{(PTR_W-1){1'b0}}, w_req_fire};
        w_tail_fl = flush_valid_i ? (issue_d + w_live_cnt) : tail_q;
        tail_d    = w_tail_fl + {{(PTR_W-1){1'b0}}, w_alloc};
        head_d    = head_q + {{(PTR_W-1){1'b0}}, w_resp_ok};
    end

    always_comb begin
        w_shamt = '0;
        if (size_q[w_head_idx][0])      w_shamt = {addr_q[w_head_idx][2:0], 3'b000};
        else if (size_q[w_head_idx][1]) w_shamt = {addr_q[w_head_idx][2:1], 4'b0000};
        else if (size_q[w_head_idx][2]) w_shamt = {addr_q[w_head_idx][2], 5'b00000};
        w_shifted = tbus_resp_data_i >> w_shamt;
        w_ext     = '0;
        if (size_q[w_head_idx][0])
            w_ext = {{(DATA_W-8){~uns_q[w_head_idx] & w_shifted[7]}}, w_shifted[7:0]};
        else if (size_q[w_head_idx][1])
            w_ext = {{(DATA_W-16){~uns_q[w_head_idx] & w_shifted[15]}}, w_shifted[15:0]};
        else if (size_q[w_head_idx][2])
            w_ext = {{(DATA_W-32){~uns_q[w_head_idx] & w_shifted[31]}}, w_shifted[31:0]};
        else if (size_q[w_head_idx][3])
            w_ext = w_shifted;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_q     <= '0;
            issue_q    <= '0;
            tail_q     <= '0;
            valid_q    <= '0;
            issued_q   <= '0;
            killed_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_prd_q   <= '0;
            wb_flag_q  <= 1'b0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            head_q     <= head_d;
            issue_q    <= issue_d;
            tail_q     <= tail_d;
            valid_q    <= w_valid_nx;
            issued_q   <= w_issued_nx;
            killed_q   <= w_killed_nx;
            if (w_alloc) begin
                valid_q[w_tail_idx]  <= 1'b1;
                issued_q[w_tail_idx] <= 1'b0;
                killed_q[w_tail_idx] <= 1'b0;
            end
            wb_valid_q <= w_wb_fire;
            if (w_wb_fire) begin
                wb_prd_q  <= prd_q[w_head_idx];
                wb_flag_q <= flag_q[w_head_idx];
                wb_idx_q  <= idx_q[w_head_idx];
                wb_data_q <= w_ext;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i && w_alloc) begin
            addr_q[w_tail_idx] <= src1_i + imm_i;
            prd_q[w_tail_idx]  <= prd_i;
            flag_q[w_tail_idx] <= robidx_flag_i;
            idx_q[w_tail_idx]  <= robidx_i;
            size_q[w_tail_idx] <= ls_size_i;
            uns_q[w_tail_idx]  <= is_unsigned_i;
        end
    end

    // A response left over from before a reset is tolerated for one cycle.
    always_ff @(posedge clock_i) begin
        post_reset_q <= reset_i;
        if (!reset_i && !post_reset_q && tbus_resp_valid_i)
            assert (valid_q[w_head_idx] && issued_q[w_head_idx]);
    end

    assign wb_valid_o       = wb_valid_q;
    assign wb_prd_o         = wb_prd_q;
    assign wb_robidx_flag_o = wb_flag_q;
    assign wb_robidx_o      = wb_idx_q;
    assign wb_data_o        = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_loadunit_mq.sv
`default_nettype none
// ============================================================================
// Module   : tb_loadunit_mq
// Purpose  : Directed self-checking bench for loadunit_mq with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loadunit_mq;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready, is_unsigned, robidx_flag;
    logic [5:0]  prd, robidx, flush_robidx;
    logic [63:0] src1, imm, req_addr, resp_data, wb_data;
    logic [3:0]  ls_size;
    logic        req_valid, req_ready, resp_valid, flush_valid, flush_flag;
    logic [1:0]  req_optype;
    logic        wb_valid, wb_flag;
    logic [5:0]  wb_prd, wb_idx;

    always #5 clk = ~clk;

    loadunit_mq #(.DEPTH(DEPTH), .DATA_W(64), .PREG_W(6), .ROB_LOG(6)) dut (
        .clock_i(clk), .reset_i(rst),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .prd_i(prd), .src1_i(src1), .imm_i(imm), .ls_size_i(ls_size),
        .is_unsigned_i(is_unsigned), .robidx_flag_i(robidx_flag), .robidx_i(robidx),
        .tbus_req_valid_o(req_valid), .tbus_req_ready_i(req_ready),
        .tbus_req_addr_o(req_addr), .tbus_req_optype_o(req_optype),
        .tbus_resp_valid_i(resp_valid), .tbus_resp_data_i(resp_data),
        .flush_valid_i(flush_valid), .flush_robidx_flag_i(flush_flag),
        .flush_robidx_i(flush_robidx),
        .wb_valid_o(wb_valid), .wb_prd_o(wb_prd), .wb_robidx_flag_o(wb_flag),
        .wb_robidx_o(wb_idx), .wb_data_o(wb_data)
    );

    int checks = 0;
    int failures = 0;
    int reqcnt = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          issued;
        bit          killed;
        logic [63:0] addr;
        logic [5:0]  prd;
        bit          flag;
        logic [5:0]  idx;
        logic [3:0]  size;
        bit          uns;
    } ent_t;

    ent_t        mq[$];
    bit          exp_wb_v = 0;
    logic [5:0]  exp_wb_prd, exp_wb_idx;
    bit          exp_wb_flag;
    logic [63:0] exp_wb_data;

    function automatic bit m_younger(bit f, logic [5:0] i, bit ff, logic [5:0] fi);
        if (f == ff) return i > fi;
        return i <= fi;
    endfunction

    function automatic int m_req_idx();
        for (int k = 0; k < mq.size(); k++)
            if (!mq[k].issued) return k;
        return -1;
    endfunction

    function automatic logic [63:0] m_load(logic [63:0] data, logic [63:0] addr,
                                           logic [3:0] size, bit uns);
        int          nbytes;
        logic [63:0] v, mask;
        bit          s;
        nbytes = size[0] ? 1 : size[1] ? 2 : size[2] ? 4 : 8;
        v = data >> (8 * addr[2:0]);
        if (nbytes < 8) begin
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
            s = v[8*nbytes-1];
            v = v & mask;
            if (!uns && s) v = v | ~mask;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        bit   rdy;
        int   ri;
        ent_t e;
        if (rst) begin
            mq.delete();
            exp_wb_v = 0;
        end else begin
            if (req_valid && req_ready) reqcnt++;
            rdy = mq.size() < DEPTH;
            ri = m_req_idx();
            exp_wb_v = 0;
            if (ri >= 0 && req_ready) mq[ri].issued = 1;
            if (flush_valid) begin
                for (int k = 0; k < mq.size(); k++)
                    if (m_younger(mq[k].flag, mq[k].idx, flush_flag, flush_robidx))
                        mq[k].killed = 1;
                for (int k = mq.size() - 1; k >= 0; k--)
                    if (mq[k].killed && !mq[k].issued) mq.delete(k);
            end
            if (resp_valid && mq.size() > 0 && mq[0].issued) begin
                if (!mq[0].killed) begin
                    exp_wb_v    = 1;
                    exp_wb_prd  = mq[0].prd;
                    exp_wb_flag = mq[0].flag;
                    exp_wb_idx  = mq[0].idx;
                    exp_wb_data = m_load(resp_data, mq[0].addr, mq[0].size, mq[0].uns);
                end
                void'(mq.pop_front());
            end
            if (instr_valid && rdy &&
                !(flush_valid && m_younger(robidx_flag, robidx, flush_flag, flush_robidx))) begin
                e.issued = 0; e.killed = 0; e.addr = src1 + imm; e.prd = prd;
                e.flag = robidx_flag; e.idx = robidx; e.size = ls_size; e.uns = is_unsigned;
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        int ri;
        if (cmp_en && !rst) begin
            ri = m_req_idx();
            chk("m_instr_ready", instr_ready, mq.size() < DEPTH);
            chk("m_req_valid", req_valid, ri >= 0);
            if (ri >= 0) begin
                chk("m_req_addr", req_addr, mq[ri].addr);
                chk("m_req_optype", req_optype, 2'b00);
            end
            chk("m_wb_valid", wb_valid, exp_wb_v);
            if (exp_wb_v) begin
                chk("m_wb_prd", wb_prd, exp_wb_prd);
                chk("m_wb_flag", wb_flag, exp_wb_flag);
                chk("m_wb_robidx", wb_idx, exp_wb_idx);
                chk("m_wb_data", wb_data, exp_wb_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] p, input logic [5:0] ri, input logic [63:0] a,
                        input logic [63:0] im, input logic [3:0] sz, input bit u);
        bit acc;
        prd = p; robidx_flag = 1'b0; robidx = ri; src1 = a; imm = im;
        ls_size = sz; is_unsigned = u; instr_valid = 1'b1;
        acc = 0;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = instr_ready;
            tick();
        end
        instr_valid = 1'b0;
        chk("push_accepted", acc, 1'b1);
    endtask

    task automatic resp(input logic [63:0] d);
        resp_valid = 1'b1;
        resp_data = d;
        tick();
        resp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; instr_valid = 0; prd = 0; src1 = 0; imm = 0; ls_size = 4'b1000;
        is_unsigned = 0; robidx_flag = 0; robidx = 0; req_ready = 1; resp_valid = 0;
        resp_data = 0; flush_valid = 0; flush_flag = 0; flush_robidx = 0;
        repeat (2) tick();
        rst = 1'b0;
        cmp_en = 1;
        chk("rst_instr_ready", instr_ready, 1'b1);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);

        // sign/zero extension cases
        push(6'd1, 6'd1, 64'h1000, 64'h3, 4'b0001, 0);
        chk("lb_req_addr", req_addr, 64'h1003);
        tick();
        resp(64'h0000_0000_8000_0000);
        chk("lb_wb_valid", wb_valid, 1'b1);
        chk("lb_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        push(6'd2, 6'd2, 64'h2000, 64'h6, 4'b0010, 1);
        tick();
        resp(64'hBEEF_0000_0000_0000);
        chk("lhu_wb_data", wb_data, 64'h0000_0000_0000_BEEF);
        push(6'd3, 6'd3, 64'h0, 64'h4, 4'b0100, 0);
        tick();
        resp(64'h8765_4321_1234_5678);
        chk("lw_wb_data", wb_data, 64'hFFFF_FFFF_8765_4321);
        push(6'd4, 6'd4, 64'h10, 64'h8, 4'b1000, 0);
        tick();
        resp(64'h0123_4567_89AB_CDEF);
        chk("ld_wb_data", wb_data, 64'h0123_4567_89AB_CDEF);

        // fill to DEPTH, fifth load waits until one response retires
        base = reqcnt;
        for (int k = 0; k < 4; k++)
            push(6'(10 + k), 6'(10 + k), 64'h3000 + 64'(8 * k), 64'h0, 4'b1000, 0);
        prd = 6'd14; robidx = 6'd14; src1 = 64'h3020; imm = 0; instr_valid = 1'b1;
        repeat (3) tick();
        chk("full_reqs", reqcnt - base, 4);
        chk("full_instr_ready", instr_ready, 1'b0);
        resp({$urandom, $urandom});
        chk("full_wb_robidx", wb_idx, 6'd10);
        chk("full_ready_after", instr_ready, 1'b1);
        tick();
        instr_valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) resp({$urandom, $urandom});
        tick();
        chk("full_reqs_total", reqcnt - base, 5);

        // flush between issued and unissued loads
        push(6'd20, 6'd3, 64'h300, 64'h0, 4'b1000, 0);
        push(6'd21, 6'd4, 64'h400, 64'h0, 4'b1000, 0);
        push(6'd22, 6'd6, 64'h600, 64'h0, 4'b1000, 0);
        push(6'd23, 6'd7, 64'h700, 64'h0, 4'b1000, 0);
        req_ready = 1'b0;
        tick();
        chk("pre_flush_addr", req_addr, 64'h700);
        flush_valid = 1'b1; flush_flag = 1'b0; flush_robidx = 6'd5;
        tick();
        flush_valid = 1'b0;
        chk("flush_req_valid", req_valid, 1'b0);
        push(6'd24, 6'd8, 64'h800, 64'h0, 4'b1000, 0);
        chk("rollback_addr", req_addr, 64'h800);
        req_ready = 1'b1;
        tick();
        resp(64'h1111_2222_3333_4444);
        chk("flush_wb3", wb_idx, 6'd3);
        resp(64'h5555_6666_7777_8888);
        chk("flush_wb4", wb_idx, 6'd4);
        resp(64'h9999_AAAA_BBBB_CCCC);
        chk("flush_killed_wb", wb_valid, 1'b0);
        resp(64'hDDDD_EEEE_FFFF_0000);
        chk("flush_wb8", wb_idx, 6'd8);

        // stalled request, then flush colliding with a younger allocation
        req_ready = 1'b0;
        push(6'd30, 6'd2, 64'h5000, 64'h10, 4'b1000, 0);
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", req_valid, 1'b1);
            chk("stall_addr", req_addr, 64'h5010);
            tick();
        end
        flush_valid = 1'b1; flush_robidx = 6'd4;
        prd = 6'd31; robidx = 6'd9; src1 = 64'h6000; imm = 0; instr_valid = 1'b1;
        tick();
        flush_valid = 1'b0; instr_valid = 1'b0;
        chk("stall_after_flush", req_addr, 64'h5010);
        req_ready = 1'b1;
        tick();
        chk("no_alloc_rob9", req_valid, 1'b0);
        resp(64'h0);
        chk("stall_wb_rob2", wb_idx, 6'd2);

        // reset with outstanding loads; stale response afterwards
        push(6'd40, 6'd40, 64'h7000, 64'h0, 4'b1000, 0);
        push(6'd41, 6'd41, 64'h7008, 64'h0, 4'b1000, 0);
        push(6'd42, 6'd42, 64'h7010, 64'h0, 4'b1000, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_req_valid", req_valid, 1'b0);
        chk("mid_rst_wb_valid", wb_valid, 1'b0);
        chk("mid_rst_ready", instr_ready, 1'b1);
        resp(64'hFFFF_FFFF_FFFF_FFFF);
        chk("stale_resp_wb", wb_valid, 1'b0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
